// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the line-wide data memory port (port 0 = icache refill, port 1 = dcache).
// Optional round-robin tie-break via `define DMEM_ARB_RR_EN; default build is fixed priority to port 1.
module dmem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 256
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              p0_enable_i,
   input  logic              p0_write_i,
   input  logic [ADDR_W-1:0] p0_addr_i,
   input  logic [DATA_W-1:0] p0_data_i,
   output logic [DATA_W-1:0] p0_data_o,
   output logic              p0_ack_o,
   input  logic              p1_enable_i,
   input  logic              p1_write_i,
   input  logic [ADDR_W-1:0] p1_addr_i,
   input  logic [DATA_W-1:0] p1_data_i,
   output logic [DATA_W-1:0] p1_data_o,
   output logic              p1_ack_o,
   output logic              mem_enable_o,
   output logic              mem_write_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_data_o,
   input  logic [DATA_W-1:0] mem_data_i,
   input  logic              mem_ack_i,
   output logic [1:0]        grant_o,
   output logic              busy_o
);

   typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

   state_t state;
   logic   p0_wins;

`ifdef DMEM_ARB_RR_EN
   logic last_owner;
   // On a tie the port that was not served last goes next.
   assign p0_wins = p0_enable_i && (!p1_enable_i || last_owner);
`else
   assign p0_wins = p0_enable_i && !p1_enable_i;
`endif

   // Completion and read data are the only paths that bypass the registers.
   assign p0_ack_o  = (state == GRANT) && grant_o[0] && mem_ack_i;
   assign p1_ack_o  = (state == GRANT) && grant_o[1] && mem_ack_i;
   assign p0_data_o = mem_data_i;
   assign p1_data_o = mem_data_i;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state        <= IDLE;
         grant_o      <= 2'b00;
         busy_o       <= 1'b0;
         mem_enable_o <= 1'b0;
         mem_write_o  <= 1'b0;
         mem_addr_o   <= '0;
         mem_data_o   <= '0;
`ifdef DMEM_ARB_RR_EN
         last_owner   <= 1'b1;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (p0_enable_i || p1_enable_i) begin
                  state        <= GRANT;
                  busy_o       <= 1'b1;
                  mem_enable_o <= 1'b1;
                  if (p0_wins) begin
                     grant_o     <= 2'b01;
                     mem_write_o <= p0_write_i;
                     mem_addr_o  <= p0_addr_i;
                     mem_data_o  <= p0_data_i;
                  end else begin
                     grant_o     <= 2'b10;
                     mem_write_o <= p1_write_i;
                     mem_addr_o  <= p1_addr_i;
                     mem_data_o  <= p1_data_i;
                  end
               end
            end
            GRANT: begin
               if (mem_ack_i) begin
                  state        <= RELEASE;
                  mem_enable_o <= 1'b0;
                  mem_write_o  <= 1'b0;
`ifdef DMEM_ARB_RR_EN
                  last_owner   <= grant_o[1];
`endif
               end
            end
            RELEASE: begin
               // Owner is still dropping its enable here, so no new arbitration yet.
               state   <= IDLE;
               grant_o <= 2'b00;
               busy_o  <= 1'b0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed requests, a latency-programmable memory model,
// and a monitor that checks every grant, ack routing and release sequence against queued expectations.
module tb_dmem_arbiter;

   typedef struct {
      int           port;
      logic         wr;
      logic [31:0]  addr;
      logic [255:0] wdata;
      logic [255:0] rdata;
      logic         tog;
   } req_t;

   logic          clk_i, rst_i;
   logic          p0_enable_i, p0_write_i, p1_enable_i, p1_write_i;
   logic [31:0]   p0_addr_i, p1_addr_i;
   logic [255:0]  p0_data_i, p1_data_i, p0_data_o, p1_data_o;
   logic          p0_ack_o, p1_ack_o;
   logic          mem_enable_o, mem_write_o, mem_ack_i, busy_o;
   logic [31:0]   mem_addr_o;
   logic [255:0]  mem_data_o, mem_data_i;
   logic [1:0]    grant_o;

   dmem_arbiter dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .p0_enable_i(p0_enable_i), .p0_write_i(p0_write_i), .p0_addr_i(p0_addr_i),
      .p0_data_i(p0_data_i), .p0_data_o(p0_data_o), .p0_ack_o(p0_ack_o),
      .p1_enable_i(p1_enable_i), .p1_write_i(p1_write_i), .p1_addr_i(p1_addr_i),
      .p1_data_i(p1_data_i), .p1_data_o(p1_data_o), .p1_ack_o(p1_ack_o),
      .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
      .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
      .grant_o(grant_o), .busy_o(busy_o)
   );

   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc = 0;
   req_t exp_q[$];
   req_t q0[$];
   req_t q1[$];
   int   lat_log[$];
   int   gap_log[$];
   logic [255:0] mem_tab [logic [31:0]];
   int   lat = 4;
   int   spur_req = 0;
   int   spur_rel_req = 0;
   logic in_grant = 0;
   int   rel = 0;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h want %h", name, act, req);
      end
   endtask

   function automatic logic [1:0] oh(input int p);
      return (p == 0) ? 2'b01 : 2'b10;
   endfunction

   initial begin
      clk_i = 0;
      forever #5 clk_i = ~clk_i;
   end

   initial forever begin
      @(posedge clk_i);
      cyc++;
   end

   // Memory model: acks after lat cycles of mem_enable_o, plus injected stray acks.
   initial begin
      int   cnt = 0;
      int   spur_seen = 0;
      int   rel_seen = 0;
      logic acked_prev = 0;
      mem_ack_i = 0;
      mem_data_i = '0;
      forever begin
         @(posedge clk_i); #1;
         mem_ack_i = 0;
         if (acked_prev && rel_seen != spur_rel_req) begin
            mem_ack_i = 1; mem_data_i = '1; rel_seen = spur_rel_req; acked_prev = 0;
         end else if (spur_seen != spur_req) begin
            mem_ack_i = 1; mem_data_i = '1; spur_seen = spur_req; acked_prev = 0;
         end else begin
            acked_prev = 0;
            if (mem_enable_o) begin
               cnt++;
               if (cnt >= lat) begin
                  mem_ack_i = 1;
                  mem_data_i = mem_tab.exists(mem_addr_o) ? mem_tab[mem_addr_o] : '0;
                  cnt = 0;
                  acked_prev = 1;
               end
            end else cnt = 0;
         end
      end
   end

   // Requester drivers: hold the request until its ack, then take the next one or drop.
   initial begin
      req_t r;
      p0_enable_i = 0; p0_write_i = 0; p0_addr_i = '0; p0_data_i = '0;
      forever begin
         @(posedge clk_i); #1;
         if (q0.size() == 0) p0_enable_i = 0;
         else begin
            r = q0.pop_front();
            p0_enable_i = 1; p0_write_i = r.wr; p0_addr_i = r.addr; p0_data_i = r.wdata;
            for (int k = 0; k < 3000; k++) begin
               @(negedge clk_i);
               if (p0_ack_o) break;
               @(posedge clk_i); #1;
               if (r.tog) p0_data_i = ~p0_data_i;
            end
         end
      end
   end

   initial begin
      req_t r;
      p1_enable_i = 0; p1_write_i = 0; p1_addr_i = '0; p1_data_i = '0;
      forever begin
         @(posedge clk_i); #1;
         if (q1.size() == 0) p1_enable_i = 0;
         else begin
            r = q1.pop_front();
            p1_enable_i = 1; p1_write_i = r.wr; p1_addr_i = r.addr; p1_data_i = r.wdata;
            for (int k = 0; k < 3000; k++) begin
               @(negedge clk_i);
               if (p1_ack_o) break;
               @(posedge clk_i); #1;
               if (r.tog) p1_data_i = ~p1_data_i;
            end
         end
      end
   end

   // Monitor: pops the expected transaction at each grant and checks it through release.
   initial begin
      req_t cur;
      logic prev_en = 0;
      logic stable = 1;
      int   since0 = -1;
      int   since1 = -1;
      int   last_ack = -100;
      logic [1:0] exp_ack;
      forever begin
         @(negedge clk_i);
         if (!rst_i) begin
            in_grant = 0; rel = 0; prev_en = 0;
         end else begin
            if (!p0_enable_i) since0 = -1; else if (since0 < 0) since0 = cyc;
            if (!p1_enable_i) since1 = -1; else if (since1 < 0) since1 = cyc;
            if (rel == 1) begin
               check("release_grant", grant_o, oh(cur.port));
               check("release_busy", busy_o, 1);
               rel = 2;
            end else if (rel == 2) begin
               check("idle_grant", grant_o, 2'b00);
               check("idle_busy", busy_o, 0);
               rel = 0;
            end
            if (!in_grant && mem_enable_o && !prev_en) begin
               if (exp_q.size() == 0) check("unexpected_grant", grant_o, 2'b00);
               else begin
                  cur = exp_q.pop_front();
                  check("grant_owner", grant_o, oh(cur.port));
                  check("grant_write", mem_write_o, cur.wr);
                  check("grant_addr", mem_addr_o, cur.addr);
                  check("grant_data", mem_data_o, cur.wdata);
                  lat_log.push_back(cyc - ((cur.port == 0) ? since0 : since1));
                  gap_log.push_back(cyc - last_ack);
                  in_grant = 1;
                  stable = 1;
               end
            end
            exp_ack = (in_grant && mem_ack_i) ? oh(cur.port) : 2'b00;
            if (mem_ack_i || p0_ack_o || p1_ack_o)
               check("ack_route", {p1_ack_o, p0_ack_o}, exp_ack);
            if (in_grant) begin
               if (mem_write_o !== cur.wr || mem_addr_o !== cur.addr || mem_data_o !== cur.wdata)
                  stable = 0;
               if (mem_ack_i) begin
                  check("ack_data", (cur.port == 0) ? p0_data_o : p1_data_o, cur.rdata);
                  check("mem_stable", stable, 1);
                  in_grant = 0;
                  rel = 1;
                  last_ack = cyc;
                  if (cur.port == 0) since0 = -1; else since1 = -1;
               end
            end
            prev_en = mem_enable_o;
         end
      end
   end

   task automatic expect_txn(input int port, input logic wr, input logic [31:0] addr,
                             input logic [255:0] wdata, input logic [255:0] rdata);
      req_t e;
      e.port = port; e.wr = wr; e.addr = addr; e.wdata = wdata; e.rdata = rdata; e.tog = 0;
      mem_tab[addr] = rdata;
      exp_q.push_back(e);
   endtask

   task automatic issue(input int port, input logic wr, input logic [31:0] addr,
                        input logic [255:0] wdata, input logic tog);
      req_t r;
      r.port = port; r.wr = wr; r.addr = addr; r.wdata = wdata; r.rdata = '0; r.tog = tog;
      if (port == 0) q0.push_back(r); else q1.push_back(r);
   endtask

   task automatic wait_done(input string name);
      logic ok = 0;
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk_i);
         if (exp_q.size() == 0 && !in_grant && rel == 0 && q0.size() == 0 && q1.size() == 0) begin
            ok = 1;
            break;
         end
      end
      check({name, "_done"}, ok, 1);
      repeat (2) @(negedge clk_i);
   endtask

   task automatic check_all_zero(input string name);
      check({name, "_mem_enable"}, mem_enable_o, 0);
      check({name, "_mem_write"}, mem_write_o, 0);
      check({name, "_mem_addr"}, mem_addr_o, 0);
      check({name, "_mem_data"}, mem_data_o, 0);
      check({name, "_grant"}, grant_o, 2'b00);
      check({name, "_busy"}, busy_o, 0);
      check({name, "_acks"}, {p1_ack_o, p0_ack_o}, 2'b00);
   endtask

   initial begin
      logic [255:0] a5, d1, d2;
      a5 = {32{8'hA5}};
      d1 = {8{32'h1234_5678}};
      d2 = {8{32'hCAFE_0001}};
      rst_i = 0;
      repeat (2) @(negedge clk_i);
      check_all_zero("reset");
      #1 rst_i = 1;
      repeat (2) @(negedge clk_i);

      // Single read on p0, memory answers after 10 cycles.
      lat = 10;
      expect_txn(0, 0, 32'h0000_0400, '0, a5);
      issue(0, 0, 32'h0000_0400, '0, 0);
      wait_done("t1");
      check("t1_req_to_enable", (lat_log.size() > 0) ? lat_log[$] : -1, 1);

      // p1 write with its data toggling during GRANT; stray ack lands in RELEASE.
      lat = 6;
      spur_rel_req++;
      expect_txn(1, 1, 32'h0000_1FE0, d1, {8{32'hDEAD_BEEF}});
      issue(1, 1, 32'h0000_1FE0, d1, 1);
      wait_done("t2");

      // Stray ack while idle.
      spur_req++;
      repeat (4) @(negedge clk_i);
      check("spur_idle_busy", busy_o, 0);
      check("spur_idle_grant", grant_o, 2'b00);
      check("spur_idle_enable", mem_enable_o, 0);

      // Tie: last owner was p1.
      lat = 3;
`ifdef DMEM_ARB_RR_EN
      expect_txn(0, 0, 32'h0000_2000, '0, {8{32'h0000_2000}});
      expect_txn(1, 0, 32'h0000_3000, '0, {8{32'h0000_3000}});
`else
      expect_txn(1, 0, 32'h0000_3000, '0, {8{32'h0000_3000}});
      expect_txn(0, 0, 32'h0000_2000, '0, {8{32'h0000_2000}});
`endif
      issue(0, 0, 32'h0000_2000, '0, 0);
      issue(1, 0, 32'h0000_3000, '0, 0);
      wait_done("t3");
      check("t3_back_to_back_gap", (gap_log.size() > 0) ? gap_log[$] : -1, 3);

      // p1 write-back then refill back to back, p0 arrives during the write-back.
      lat = 6;
      expect_txn(1, 1, 32'h0000_4000, d2, {8{32'h0000_4000}});
`ifdef DMEM_ARB_RR_EN
      expect_txn(0, 0, 32'h0000_5000, '0, {8{32'h0000_5000}});
      expect_txn(1, 0, 32'h0000_6000, '0, {8{32'h0000_6000}});
`else
      expect_txn(1, 0, 32'h0000_6000, '0, {8{32'h0000_6000}});
      expect_txn(0, 0, 32'h0000_5000, '0, {8{32'h0000_5000}});
`endif
      issue(1, 1, 32'h0000_4000, d2, 0);
      issue(1, 0, 32'h0000_6000, '0, 0);
      repeat (3) @(negedge clk_i);
      issue(0, 0, 32'h0000_5000, '0, 0);
      wait_done("t4");
      check("t4_gap", (gap_log.size() > 0) ? gap_log[$] : -1, 3);

      // Reset mid-GRANT, then the still-pending p0 request is granted again.
      lat = 50;
      expect_txn(0, 1, 32'h0000_0800, d1, {8{32'h0000_0800}});
      expect_txn(0, 1, 32'h0000_0800, d1, {8{32'h0000_0800}});
      issue(0, 1, 32'h0000_0800, d1, 0);
      for (int k = 0; k < 20; k++) begin
         @(negedge clk_i);
         if (mem_enable_o) break;
      end
      check("t5_granted", mem_enable_o, 1);
      repeat (3) @(negedge clk_i);
      #2 rst_i = 0;
      #1 check_all_zero("midreset");
      lat = 4;
      @(posedge clk_i);
      @(negedge clk_i);
      #1 rst_i = 1;
      wait_done("t5");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule
